// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the instruction word width and the default reset PC.
package fetch_pkg;

  localparam int INST_W = 32;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // S_DROP waits out a response whose request was made stale by a redirect.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch unit.
// A redirect always wins; otherwise the PC steps by 4 when the offered
// instruction is consumed, and holds in every other cycle. The +4 wraps
// silently at 2^XLEN.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   redir_valid  load redir_pc this cycle
//   redir_pc     redirect target
//   advance      step to the next sequential instruction
//   pc           current program counter
module fetch_pc_reg #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redir_valid) begin
      pc <= redir_pc;
    end else if (advance) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch unit.
// Issues one read per PC, waits for the response, offers the instruction to
// decode and steps the PC by 4 when decode consumes it. Redirects override
// everything; a response belonging to a request made stale by a redirect is
// waited out in S_DROP and discarded.
//
// Optional feature: define INST_FETCH_MISALIGN_CHK_EN to turn a PC with
// pc[1:0]!=0 into a fault entry (out_fault=1, out_inst=0) offered without a
// memory request. Without it the low PC bits are ignored for the request and
// out_fault is tied to 0.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      instruction read request handshake
//   req_addr                 fetch address
//   resp_valid/resp_data     read response (always accepted)
//   out_valid/out_ready      fetched-instruction handshake to decode
//   out_pc/out_inst          PC and word of the offered entry
//   out_fault                offered entry is a misaligned-fetch fault
//   redir_valid/redir_pc     redirect to a new PC
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [XLEN-1:0]   req_addr,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              redir_valid,
  input  logic [XLEN-1:0]   redir_pc,
  output logic              out_fault
);

  fetch_state_t    state;
  fetch_state_t    next_state;
  logic [XLEN-1:0] pc;
  logic            run;
  logic            advance;
  logic            capture;
  logic            handshake;
`ifdef INST_FETCH_MISALIGN_CHK_EN
  logic            misaligned;
  logic            take_fault;
`endif

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC[XLEN-1:0])
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .advance     (advance),
    .pc          (pc)
  );

  // run stays low until the first edge after reset release, so no request
  // is visible while reset is asserted or before that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

`ifdef INST_FETCH_MISALIGN_CHK_EN
  assign misaligned = (pc[1:0] != 2'b00);
  assign req_valid  = run && (state == S_REQ) && !misaligned;
  assign req_addr   = pc;
`else
  assign req_valid  = run && (state == S_REQ);
  assign req_addr   = {pc[XLEN-1:2], 2'b00};
`endif

  assign handshake = req_valid && req_ready;
  assign out_valid = (state == S_OUT);
  assign out_pc    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= next_state;
    end
  end

  // Redirect is tested first in every state so it dominates handshakes and
  // responses arriving in the same cycle.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    advance    = 1'b0;
`ifdef INST_FETCH_MISALIGN_CHK_EN
    take_fault = 1'b0;
`endif
    case (state)
      S_REQ: begin
        if (redir_valid) begin
          if (handshake) begin
            next_state = S_DROP;
          end
        end
`ifdef INST_FETCH_MISALIGN_CHK_EN
        else if (run && misaligned) begin
          next_state = S_OUT;
          take_fault = 1'b1;
        end
`endif
        else if (handshake) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir_valid) begin
          next_state = resp_valid ? S_REQ : S_DROP;
        end else if (resp_valid) begin
          next_state = S_OUT;
          capture    = 1'b1;
        end
      end
      S_OUT: begin
        if (redir_valid) begin
          next_state = S_REQ;
        end else if (out_ready) begin
          next_state = S_REQ;
          advance    = 1'b1;
        end
      end
      S_DROP: begin
        if (resp_valid) begin
          next_state = S_REQ;
        end
      end
      default: next_state = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inst <= '0;
    end else if (capture) begin
      out_inst <= resp_data;
    end
`ifdef INST_FETCH_MISALIGN_CHK_EN
    else if (take_fault) begin
      out_inst <= '0;
    end
`endif
  end

`ifdef INST_FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_fault <= 1'b0;
    end else if (capture) begin
      out_fault <= 1'b0;
    end else if (take_fault) begin
      out_fault <= 1'b1;
    end
  end
`else
  assign out_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model of the fetch
// unit (PC, outstanding request, offered entry) checked every cycle.
// Honours INST_FETCH_MISALIGN_CHK_EN when defined.
module tb_inst_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  inst_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_fault   (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: PC, whether a request is in flight (and
  // whether a redirect has made it stale), and the entry offered to decode.
  logic [63:0] m_pc;
  logic        m_out;
  logic [31:0] m_inst;
  logic        m_fault;
  logic        m_outst;
  logic        m_taint;
  logic        m_live;
  logic        snap_ok;

  logic        s_req_ready, s_resp_valid, s_out_ready, s_redir;
  logic [31:0] s_resp_data;
  logic [63:0] s_redir_pc;

  function automatic logic may_request(input logic [63:0] pc);
`ifdef INST_FETCH_MISALIGN_CHK_EN
    return pc[1:0] == 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] fetch_addr(input logic [63:0] pc);
`ifdef INST_FETCH_MISALIGN_CHK_EN
    return pc;
`else
    return pc & ~64'd3;
`endif
  endfunction

  task automatic modelStep();
    logic idle, hs, rsp, cons, nout;
    logic [63:0] npc;
    idle = m_live && !m_outst && !m_out;
    hs   = idle && may_request(m_pc) && s_req_ready;
    rsp  = m_outst && s_resp_valid;
    cons = m_out && s_out_ready && !s_redir;
    npc  = s_redir ? s_redir_pc : (cons ? m_pc + 64'd4 : m_pc);
    nout = m_out && !(s_redir || s_out_ready);
    if (hs) begin
      m_outst = 1'b1;
      m_taint = s_redir;
    end else if (rsp) begin
      m_outst = 1'b0;
      if (!m_taint && !s_redir) begin
        nout    = 1'b1;
        m_inst  = s_resp_data;
        m_fault = 1'b0;
      end
    end else if (m_outst && s_redir) begin
      m_taint = 1'b1;
    end
`ifdef INST_FETCH_MISALIGN_CHK_EN
    if (idle && !may_request(m_pc) && !s_redir) begin
      nout    = 1'b1;
      m_inst  = 32'h0;
      m_fault = 1'b1;
    end
`endif
    m_out  = nout;
    m_pc   = npc;
    m_live = 1'b1;
  endtask

  // Every cycle: advance the model over the previous cycle's inputs and
  // compare all meaningful outputs.
  always @(negedge clk) begin
    logic exp_req;
    if (!rst_n) begin
      m_pc    = RST_PC;
      m_out   = 1'b0;
      m_inst  = 32'h0;
      m_fault = 1'b0;
      m_outst = 1'b0;
      m_taint = 1'b0;
      m_live  = 1'b0;
      snap_ok = 1'b0;
      checkOutput("reset_req_valid", req_valid, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_inst", out_inst, 0);
      checkOutput("reset_out_fault", out_fault, 0);
    end else begin
      if (snap_ok) modelStep();
      exp_req = m_live && !m_outst && !m_out && may_request(m_pc);
      checkOutput("model_req_valid", req_valid, exp_req);
      if (exp_req) checkOutput("model_req_addr", req_addr, fetch_addr(m_pc));
      checkOutput("model_out_valid", out_valid, m_out);
      if (m_out) begin
        checkOutput("model_out_pc", out_pc, m_pc);
        checkOutput("model_out_inst", out_inst, m_inst);
        checkOutput("model_out_fault", out_fault, m_fault);
      end
`ifndef INST_FETCH_MISALIGN_CHK_EN
      checkOutput("model_fault_tied", out_fault, 0);
`endif
      s_req_ready  = req_ready;
      s_resp_valid = resp_valid;
      s_resp_data  = resp_data;
      s_out_ready  = out_ready;
      s_redir      = redir_valid;
      s_redir_pc   = redir_pc;
      snap_ok      = 1'b1;
    end
  end

  // Random traffic with a one-slot memory answering 1..3 cycles after accept.
  task automatic applyStimulus(input int cycles);
    bit hs;
    bit rsp_now;
    bit busy = 0;
    int wait_c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      hs      = req_valid && req_ready;
      rsp_now = resp_valid;
      @(posedge clk);
      #1;
      if (rsp_now) busy = 0;
      if (hs) begin
        busy   = 1;
        wait_c = $urandom_range(0, 2);
      end
      resp_valid = 1'b0;
      if (busy) begin
        if (wait_c == 0) begin
          resp_valid = 1'b1;
          resp_data  = $urandom;
        end else begin
          wait_c--;
        end
      end
      req_ready   = ($urandom_range(0, 9) < 7);
      out_ready   = $urandom_range(0, 1) == 1;
      redir_valid = ($urandom_range(0, 9) == 0);
      redir_pc    = {(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h0), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) redir_pc[1:0] = 2'b00;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = 32'h0;
    out_ready   = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 64'h0;
    repeat (3) @(posedge clk);
    #1;

    // Reset release and a single fetch with one-cycle response latency
    rst_n     = 1'b1;
    req_ready = 1'b1;
    step();
    checkOutput("first_req_valid", req_valid, 1);
    checkOutput("first_req_addr", req_addr, 64'h8000_0000);
    step();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'h0000_0413;
    checkOutput("wait_req_valid", req_valid, 0);
    step();
    resp_valid = 1'b0;
    checkOutput("first_out_valid", out_valid, 1);
    checkOutput("first_out_pc", out_pc, 64'h8000_0000);
    checkOutput("first_out_inst", out_inst, 32'h0000_0413);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("next_req_addr", req_addr, 64'h8000_0004);
    checkOutput("next_out_valid", out_valid, 0);

    // Decode stalls for 5 cycles
    req_ready = 1'b1;
    step();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'h1234_5678;
    step();
    resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_out_pc", out_pc, 64'h8000_0004);
      checkOutput("stall_out_inst", out_inst, 32'h1234_5678);
      checkOutput("stall_req_valid", req_valid, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Redirect while waiting; the stale response must be dropped
    req_ready = 1'b1;
    step();
    req_ready   = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0100;
    step();
    redir_valid = 1'b0;
    checkOutput("drop_req_valid", req_valid, 0);
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_BEEF;
    step();
    resp_valid = 1'b0;
    checkOutput("drop_out_valid", out_valid, 0);
    checkOutput("drop_req_valid_after", req_valid, 1);
    checkOutput("drop_req_addr", req_addr, 64'h8000_0100);
    step();
    checkOutput("drop_out_valid_later", out_valid, 0);

    // Redirect coinciding with consumption discards the entry
    req_ready = 1'b1;
    step();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'hCAFE_0001;
    step();
    resp_valid = 1'b0;
    checkOutput("held_out_pc", out_pc, 64'h8000_0100);
    out_ready   = 1'b1;
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0200;
    step();
    out_ready   = 1'b0;
    redir_valid = 1'b0;
    checkOutput("redir_out_valid", out_valid, 0);
    checkOutput("redir_req_addr", req_addr, 64'h8000_0200);

    // Misaligned redirect target
    redir_valid = 1'b1;
    redir_pc    = 64'h8000_0002;
    step();
    redir_valid = 1'b0;
`ifdef INST_FETCH_MISALIGN_CHK_EN
    checkOutput("misalign_no_req", req_valid, 0);
    step();
    checkOutput("misalign_out_valid", out_valid, 1);
    checkOutput("misalign_out_fault", out_fault, 1);
    checkOutput("misalign_out_inst", out_inst, 0);
    checkOutput("misalign_out_pc", out_pc, 64'h8000_0002);
`else
    checkOutput("misalign_req_valid", req_valid, 1);
    checkOutput("misalign_req_addr", req_addr, 64'h8000_0000);
    req_ready = 1'b1;
    step();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'h0000_0013;
    step();
    resp_valid = 1'b0;
    checkOutput("misalign_out_pc", out_pc, 64'h8000_0002);
    checkOutput("misalign_out_fault", out_fault, 0);
`endif

    // PC wraps at the top of the address space
    redir_valid = 1'b1;
    redir_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redir_valid = 1'b0;
    req_ready   = 1'b1;
    step();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'h0000_0073;
    step();
    resp_valid = 1'b0;
    checkOutput("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("wrap_req_addr", req_addr, 64'h0);

    // Asynchronous reset during S_WAIT
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_req_valid", req_valid, 0);
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_out_inst", out_inst, 0);
    checkOutput("async_out_fault", out_fault, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    checkOutput("rerun_req_valid", req_valid, 1);
    checkOutput("rerun_req_addr", req_addr, RST_PC);

    applyStimulus(3000);

    resp_valid  = 1'b0;
    redir_valid = 1'b0;
    req_ready   = 1'b0;
    out_ready   = 1'b0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
